// File: rtl/redix8_sched_pkg.sv
// Shared types and defaults for the radix-8 multiplier lane scheduler.
package redix8_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_WAIT,
    S_ISSUE
  } state_e;

  localparam int A_LAT_DEF   = 2;
  localparam int MUL_LAT_DEF = 3;
  // Wide enough for the largest legal requester count (8).
  localparam int ID_W        = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/redix8_mul_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after i_ptr, returned one-hot.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_found
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_back;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_gnt;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_dbl     = {i_req, i_req} >> i_ptr;
  assign w_rot     = w_dbl[N-1:0];
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));
  assign w_back    = {w_rot_gnt, w_rot_gnt} << i_ptr;
  assign o_gnt     = w_back[2*N-1:N];
  assign o_found   = |i_req;

endmodule

// File: rtl/redix8_mul_sched.sv
// Shares one multiplier lane among REQ_NUM requesters; A is loaded A_LAT cycles before B issue.
// Optional A-operand reuse (back-to-back issue on matching A): define REDIX8_SCHED_A_REUSE_EN.
module redix8_mul_sched
  import redix8_sched_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int A_LAT   = A_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  localparam int IW     = $clog2(REQ_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        iReqValid,
  input  logic [REQ_NUM-1:0][7:0]   iReqA,
  input  logic [REQ_NUM-1:0][7:0]   iReqB,
  output logic [REQ_NUM-1:0]        oReqReady,
  output logic                      oMulAEn,
  output logic [7:0]                oMulA,
  output logic [7:0]                oMulB,
  input  logic [15:0]               iMulRslt,
  output logic                      oRspValid,
  output logic [IW-1:0]             oRspId,
  output logic [15:0]               oRspData,
  output logic                      oBusy
);

  localparam int CW = $clog2(A_LAT + 1);
  localparam state_e LOAD_NXT = (A_LAT == 1) ? S_ISSUE : S_WAIT;

  state_e                   r_state, w_nxt;
  logic [IW-1:0]            r_ptr, r_lock;
  logic [CW-1:0]            r_cnt;
  tag_t [MUL_LAT-1:0]       r_tag;
  logic                     r_post_rst;

  logic [REQ_NUM-1:0]       w_gnt, w_ready;
  logic                     w_found, w_hit, w_inflight, w_hold;
  logic [IW-1:0]            w_win, w_push_id;
  logic                     w_aen, w_push, w_rsp_vld, w_unused_id;
  logic [7:0]               w_mul_a, w_mul_b;

  rr_arbiter #(.N(REQ_NUM), .PW(IW)) u_arb (
    .i_req   (iReqValid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_found (w_found)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (w_gnt[i]) w_win = IW'(i);
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) w_inflight = w_inflight | r_tag[i].valid;
  end

  // Nothing is granted during reset or in the first cycle after it.
  assign w_hold = rst | r_post_rst;

`ifdef REDIX8_SCHED_A_REUSE_EN
  logic       r_a_vld;
  logic [7:0] r_a;

  assign w_hit = r_a_vld && (iReqA[w_win] == r_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_vld <= 1'b0;
      r_a     <= '0;
    end else if (w_aen) begin
      r_a_vld <= 1'b1;
      r_a     <= w_mul_a;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (!r_post_rst) begin
      case (r_state)
        S_IDLE:  if (w_found && !w_hit) w_nxt = w_inflight ? S_DRAIN : LOAD_NXT;
        S_DRAIN: if (!w_inflight) w_nxt = LOAD_NXT;
        S_WAIT:  if (r_cnt == CW'(1)) w_nxt = S_ISSUE;
        S_ISSUE: w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready   = '0;
    w_aen     = 1'b0;
    w_mul_a   = '0;
    w_mul_b   = '0;
    w_push    = 1'b0;
    w_push_id = r_lock;
    if (!w_hold) begin
      case (r_state)
        S_IDLE: if (w_found) begin
          if (w_hit) begin
            w_ready   = w_gnt;
            w_mul_b   = iReqB[w_win];
            w_push    = 1'b1;
            w_push_id = w_win;
          end else if (!w_inflight) begin
            w_aen   = 1'b1;
            w_mul_a = iReqA[w_win];
          end
        end
        S_DRAIN: if (!w_inflight) begin
          w_aen   = 1'b1;
          w_mul_a = iReqA[r_lock];
        end
        S_ISSUE: if (iReqValid[r_lock]) begin
          w_ready[r_lock] = 1'b1;
          w_mul_b         = iReqB[r_lock];
          w_push          = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_lock     <= '0;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_post_rst <= 1'b1;
    end else begin
      r_post_rst      <= 1'b0;
      r_tag[0].valid  <= w_push;
      r_tag[0].id     <= ID_W'(w_push_id);
      for (int i = 1; i < MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (w_push)
        r_ptr <= (w_push_id == IW'(REQ_NUM - 1)) ? '0 : w_push_id + 1'b1;
      if (!w_hold && r_state == S_IDLE && w_found && !w_hit)
        r_lock <= w_win;
      if (w_aen)                 r_cnt <= CW'(A_LAT - 1);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_rsp_vld   = r_tag[MUL_LAT-1].valid & ~rst;
  assign w_unused_id = ^r_tag[MUL_LAT-1].id;

  assign oReqReady = w_ready;
  assign oMulAEn   = w_aen;
  assign oMulA     = w_mul_a;
  assign oMulB     = w_mul_b;
  assign oRspValid = w_rsp_vld;
  assign oRspId    = w_rsp_vld ? r_tag[MUL_LAT-1].id[IW-1:0] : '0;
  assign oRspData  = w_rsp_vld ? iMulRslt : '0;
  assign oBusy     = ~w_hold & ((r_state != S_IDLE) | w_inflight);

endmodule

// File: tb/tb_redix8_mul_sched.sv
// Bench for redix8_mul_sched: external multiplier model, issue/response scoreboard, directed scenarios.
module tb_redix8_mul_sched;
  localparam int N = 4, AL = 2, ML = 3, IW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_v = '0;
  logic [N-1:0][7:0]    req_a = '0;
  logic [N-1:0][7:0]    req_b = '0;
  logic [N-1:0]         rdy;
  logic                 aen;
  logic [7:0]           mul_a, mul_b;
  logic [15:0]          rslt;
  logic                 rsp_v;
  logic [IW-1:0]        rsp_id;
  logic [15:0]          rsp_d;
  logic                 busy;

  int total = 0, bad = 0, cyc = 0;

  redix8_mul_sched #(.REQ_NUM(N), .A_LAT(AL), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .iReqValid(req_v), .iReqA(req_a), .iReqB(req_b),
    .oReqReady(rdy), .oMulAEn(aen), .oMulA(mul_a), .oMulB(mul_b), .iMulRslt(rslt),
    .oRspValid(rsp_v), .oRspId(rsp_id), .oRspData(rsp_d), .oBusy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier: A register loaded on oMulAEn, product of A and issued B after ML cycles.
  logic [7:0]  m_a = '0;
  logic [15:0] m_pipe [ML];
  initial for (int i = 0; i < ML; i++) m_pipe[i] = '0;
  always @(posedge clk) begin
    if (aen) m_a <= mul_a;
    m_pipe[0] <= 16'(m_a) * 16'(mul_b);
    for (int i = 1; i < ML; i++) m_pipe[i] <= m_pipe[i-1];
  end
  assign rslt = m_pipe[ML-1];

  typedef struct { int cyc; int id; int val; } ev_t;
  ev_t q[$], ld_log[$], iss_log[$], rsp_log[$];
  logic [N-1:0] xfer = '0;
  bit           ld_v = 0;
  logic [7:0]   ld_a = '0;
  int           ld_cyc = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t at(ev_t qq[$], int i);
    ev_t e = '{-1, -1, -1};
    if (i < qq.size()) e = qq[i];
    return e;
  endfunction

  // Scoreboard: every issue must be a valid requester with its own operands already
  // loaded; its product is owed exactly ML cycles later, nothing else may respond.
  always @(negedge clk) begin
    int k;
    xfer = rdy & req_v;
    if (rsp_v) rsp_log.push_back('{cyc, int'(rsp_id), int'(rsp_d)});
    if (rst) begin
      q.delete();
      ld_v = 0;
    end else begin
      if (aen) begin
        chk("aen_while_inflight", q.size(), 0);
        ld_v = 1; ld_a = mul_a; ld_cyc = cyc;
        ld_log.push_back('{cyc, 0, int'(mul_a)});
      end
      if (q.size() > 0) chk("busy_inflight", busy, 1);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("rsp_valid", rsp_v, 1);
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_data", rsp_d, q[0].val);
        void'(q.pop_front());
      end else begin
        chk("rsp_unexpected", rsp_v, 0);
      end
      if (rdy != '0) begin
        k = 0;
        for (int i = 0; i < N; i++) if (rdy[i]) k = i;
        chk("rdy_onehot", $countones(rdy), 1);
        chk("rdy_valid", req_v[k], 1);
        chk("mul_b", mul_b, req_b[k]);
        chk("a_loaded", ld_v ? int'(ld_a) : -1, req_a[k]);
`ifndef REDIX8_SCHED_A_REUSE_EN
        chk("load_to_issue", cyc - ld_cyc, AL);
`endif
        q.push_back('{cyc + ML, k, int'(req_a[k]) * int'(req_b[k])});
        iss_log.push_back('{cyc, k, int'(mul_b)});
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_v = req_v & ~xfer;
    end
  endtask

  task automatic chk_zero(string p);
    chk({p, "_rdy"}, rdy, 0);     chk({p, "_aen"}, aen, 0);
    chk({p, "_mula"}, mul_a, 0);  chk({p, "_mulb"}, mul_b, 0);
    chk({p, "_rspv"}, rsp_v, 0);  chk({p, "_rspid"}, rsp_id, 0);
    chk({p, "_rspd"}, rsp_d, 0);  chk({p, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; req_v = '0;
    repeat (2) begin @(negedge clk); chk_zero("rst"); end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); chk_zero("post_rst");
    step(1);
    ld_log.delete(); iss_log.delete(); rsp_log.delete();
  endtask

  initial begin
    ev_t e0, e1;
    int  t2_d [4] = '{70, 140, 210, 280};

    // Single op: load at t, issue t+2, response t+5 with 3*5.
    do_reset();
    req_a[0] = 8'd3; req_b[0] = 8'd5; req_v[0] = 1'b1;
    step(10);
    e0 = at(ld_log, 0); e1 = at(iss_log, 0);
    chk("t1_load_a", e0.val, 3);
    chk("t1_iss_id", e1.id, 0);
    chk("t1_iss_lat", e1.cyc - e0.cyc, 2);
    chk("t1_iss_b", e1.val, 5);
    e1 = at(rsp_log, 0);
    chk("t1_rsp_lat", e1.cyc - e0.cyc, 5);
    chk("t1_rsp_id", e1.id, 0);
    chk("t1_rsp_data", e1.val, 15);
    chk("t1_rsp_cnt", rsp_log.size(), 1);

    // Four requesters sharing A=7: issue order and results.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 8'd7; req_b[i] = 8'(10 * (i + 1));
    end
    req_v = '1;
    step(60);
    for (int i = 0; i < N; i++) begin
      chk("t2_iss_id", at(iss_log, i).id, i);
      chk("t2_rsp_id", at(rsp_log, i).id, i);
      chk("t2_rsp_data", at(rsp_log, i).val, t2_d[i]);
`ifdef REDIX8_SCHED_A_REUSE_EN
      chk("t2_iss_b2b", at(iss_log, i).cyc - at(iss_log, 0).cyc, i);
      chk("t2_rsp_b2b", at(rsp_log, i).cyc - at(rsp_log, 0).cyc, i);
`endif
    end
`ifdef REDIX8_SCHED_A_REUSE_EN
    chk("t2_loads", ld_log.size(), 1);
`else
    chk("t2_loads", ld_log.size(), 4);
`endif

    // New A must wait for the in-flight op to drain.
    do_reset();
    req_a[1] = 8'd2; req_b[1] = 8'd3; req_v[1] = 1'b1;
    step(3);
    req_a[2] = 8'd9; req_b[2] = 8'd4; req_v[2] = 1'b1;
    step(14);
    e0 = at(ld_log, 1); e1 = at(rsp_log, 0);
    chk("t3_load2_a", e0.val, 9);
    chk("t3_rsp1_data", e1.val, 6);
    chk("t3_load_after_rsp", e0.cyc - e1.cyc, 1);
    chk("t3_load2_lat", e0.cyc - at(ld_log, 0).cyc, 6);
    chk("t3_rsp2_id", at(rsp_log, 1).id, 2);
    chk("t3_rsp2_data", at(rsp_log, 1).val, 36);

    // Locked requester withdraws during WAIT: cancelled, pointer stays at 0.
    do_reset();
    req_a[0] = 8'd4; req_b[0] = 8'd6; req_v[0] = 1'b1;
    step(1);
    req_v[0] = 1'b0;
    step(3);
    chk("t4_no_issue", iss_log.size(), 0);
    req_a[1] = 8'd5; req_b[1] = 8'd2;
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    step(30);
    chk("t4_iss_cnt", iss_log.size(), 2);
    chk("t4_first_id", at(iss_log, 0).id, 0);
    chk("t4_second_id", at(iss_log, 1).id, 1);
    chk("t4_rsp0", at(rsp_log, 0).val, 24);
    chk("t4_rsp1", at(rsp_log, 1).val, 10);

    // Reset while an op is in flight and another is waiting to load.
    do_reset();
    req_a[0] = 8'd5; req_b[0] = 8'd6; req_a[1] = 8'd8; req_b[1] = 8'd2;
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    step(4);
    chk("t5_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk); chk_zero("mid_rst");
    step(1);
    rst = 1'b0;
    @(negedge clk); chk_zero("after_mid_rst");
    step(20);
    chk("t5_loads", ld_log.size(), 2);
    chk("t5_reload_a", at(ld_log, 1).val, 8);
    chk("t5_reload_gap", at(ld_log, 1).cyc - at(ld_log, 0).cyc, 6);
    chk("t5_rsp_cnt", rsp_log.size(), 1);
    chk("t5_rsp_id", at(rsp_log, 0).id, 1);
    chk("t5_rsp_data", at(rsp_log, 0).val, 16);

    // Operand extremes.
    do_reset();
    req_a[3] = 8'd255; req_b[3] = 8'd255; req_v[3] = 1'b1;
    step(10);
    req_a[1] = 8'd0; req_b[1] = 8'd200; req_v[1] = 1'b1;
    step(12);
    chk("t6_max_id", at(rsp_log, 0).id, 3);
    chk("t6_max_data", at(rsp_log, 0).val, 65025);
    chk("t6_zero_id", at(rsp_log, 1).id, 1);
    chk("t6_zero_data", at(rsp_log, 1).val, 0);
    chk("t6_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
